// File: rtl/immed_gen_pipe_pkg.sv
// otter_imm_pkg: immediate-format selector encoding and legal parameter limits
package otter_imm_pkg;
  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100,
    IMM_Z = 3'b101
  } imm_sel_t;
  localparam int XLEN_32    = 32;
  localparam int XLEN_64    = 64;
  localparam int MAX_STAGES = 3;
endpackage

// File: rtl/immed_gen_pipe_if.sv
// immed_gen_pipe_if: decode-side bus of the immediate pipe; err_count exists only with IMM_ERR_CNT_EN
interface immed_gen_pipe_if #(parameter int XLEN = 32);
  logic [31:0]     ir;
  logic [2:0]      immed_sel;
  logic            valid_in;
  logic            stall;
  logic            flush;
  logic [XLEN-1:0] immed_ext;
  logic            valid_out;
  logic            imm_err;
`ifdef IMM_ERR_CNT_EN
  logic [7:0]      err_count;
`endif
  modport master (
    output ir, immed_sel, valid_in, stall, flush,
    input  immed_ext, valid_out, imm_err
`ifdef IMM_ERR_CNT_EN
    , input err_count
`endif
  );
  modport slave (
    input  ir, immed_sel, valid_in, stall, flush,
    output immed_ext, valid_out, imm_err
`ifdef IMM_ERR_CNT_EN
    , output err_count
`endif
  );
endinterface

// File: rtl/immed_gen_pipe_imm_extract.sv
// imm_extract: combinational I/S/B/U/J/Z immediate decode, sign-extended to XLEN
module imm_extract
  import otter_imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     ir,
  input  logic [2:0]      sel,
  output logic            err,
  output logic [XLEN-1:0] data
);
  logic [31:0] raw;
  always_comb begin
    raw = sel == IMM_I ? {{20{ir[31]}}, ir[31:20]} :
          sel == IMM_S ? {{20{ir[31]}}, ir[31:25], ir[11:7]} :
          sel == IMM_B ? {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0} :
          sel == IMM_U ? {ir[31:12], 12'b0} :
          sel == IMM_J ? {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0} :
          sel == IMM_Z ? {27'b0, ir[19:15]} : 32'b0;
  end
  // Z has bit 31 clear, so the common sign extension leaves its upper bits zero
  assign data = XLEN'($signed(raw));
  assign err  = sel[2] & sel[1];
endmodule

// File: rtl/immed_gen_pipe.sv
// immed_gen_pipe: STAGES-deep registered immediate generator; define IMM_ERR_CNT_EN to add err_count
module immed_gen_pipe
  import otter_imm_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 1
) (
  input logic             clk,
  input logic             rst_n,
  immed_gen_pipe_if.slave bus
);
  if (!(XLEN == XLEN_32 || XLEN == XLEN_64) || STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad
    $fatal(1, "immed_gen_pipe: unsupported XLEN/STAGES");
  end

  logic            ext_err;
  logic [XLEN-1:0] ext_data;

  imm_extract #(.XLEN(XLEN)) u_ext (
    .ir   (bus.ir),
    .sel  (bus.immed_sel),
    .err  (ext_err),
    .data (ext_data)
  );

  // index 0 is the decoded input, index k the output of stage k
  logic            sv [STAGES+1];
  logic            se [STAGES+1];
  logic [XLEN-1:0] sd [STAGES+1];

  assign sv[0] = bus.valid_in;
  assign se[0] = ext_err;
  assign sd[0] = ext_data;

  for (genvar i = 0; i < STAGES; i++) begin : g_stg
    logic            v;
    logic            e;
    logic [XLEN-1:0] d;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v <= 1'b0;
        e <= 1'b0;
        d <= '0;
      end else if (bus.flush) begin
        v <= 1'b0;
        e <= 1'b0;
      end else if (!bus.stall) begin
        v <= sv[i];
        if (sv[i]) begin
          e <= se[i];
          d <= sd[i];
        end
      end
    end
    assign sv[i+1] = v;
    assign se[i+1] = e;
    assign sd[i+1] = d;
  end

  assign bus.valid_out = sv[STAGES];
  assign bus.imm_err   = se[STAGES];
  assign bus.immed_ext = sd[STAGES];

`ifdef IMM_ERR_CNT_EN
  logic [7:0] cnt;
  // counts on the edge an erroneous entry lands in the last stage, so a stalled one is counted once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (!bus.flush && !bus.stall && sv[STAGES-1] && se[STAGES-1] && cnt != 8'hFF)
      cnt <= cnt + 8'd1;
  end
  assign bus.err_count = cnt;
`endif
endmodule

// File: tb/tb_immed_gen_pipe.sv
// tb_immed_gen_pipe: table, directed and randomized checks of a 32b/1-stage and a 64b/3-stage instance
module tb_immed_gen_pipe;
  import otter_imm_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] ir;
  logic [2:0]  sel;
  logic        vin, stall, flush;
  logic        mon;

  immed_gen_pipe_if #(.XLEN(32)) ia ();
  immed_gen_pipe_if #(.XLEN(64)) ib ();

  assign ia.ir = ir;  assign ia.immed_sel = sel;  assign ia.valid_in = vin;
  assign ia.stall = stall;  assign ia.flush = flush;
  assign ib.ir = ir;  assign ib.immed_sel = sel;  assign ib.valid_in = vin;
  assign ib.stall = stall;  assign ib.flush = flush;

  immed_gen_pipe #(.XLEN(32), .STAGES(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  immed_gen_pipe #(.XLEN(64), .STAGES(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] i, input logic [2:0] s, input logic v,
                       input logic st, input logic fl);
    ir = i; sel = s; vin = v; stall = st; flush = fl;
  endtask

  // immediate value as a signed number: field value minus 2^width when the sign bit is set
  function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] s);
    longint f;
    int w;
    f = 0;
    w = 0;
    case (s)
      3'd0: begin f = longint'(i[31:20]); w = 12; end
      3'd1: begin f = longint'({i[31:25], i[11:7]}); w = 12; end
      3'd2: begin f = longint'({i[31], i[7], i[30:25], i[11:8], 1'b0}); w = 13; end
      3'd3: begin f = longint'({i[31:12], 12'b0}); w = 32; end
      3'd4: begin f = longint'({i[31], i[19:12], i[20], i[30:21], 1'b0}); w = 21; end
      3'd5: return {59'b0, i[19:15]};
      default: return 64'd0;
    endcase
    return i[31] ? f - (longint'(1) << w) : f;
  endfunction

  // behavioural model: each instance is a line of slots that shifts by one on every unstalled edge
  typedef struct {bit v; logic [63:0] d; bit e;} ent_t;
  ent_t m [2][3];
  int   dep [2] = '{1, 3};
  int   cnt [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int x = 0; x < 2; x++) begin
        for (int k = 0; k < 3; k++) m[x][k] = '{1'b0, 64'd0, 1'b0};
        cnt[x] = 0;
      end
    end else if (flush) begin
      for (int x = 0; x < 2; x++)
        for (int k = 0; k < 3; k++) begin
          m[x][k].v = 1'b0;
          m[x][k].e = 1'b0;
        end
    end else if (!stall) begin
      for (int x = 0; x < 2; x++) begin
        for (int k = 2; k > 0; k--) m[x][k] = m[x][k-1];
        m[x][0] = '{vin, ref_imm(ir, sel), vin && sel >= 3'd6};
        if (m[x][dep[x]-1].v && m[x][dep[x]-1].e && cnt[x] < 255) cnt[x]++;
      end
    end
  end

  always @(negedge clk) begin
    if (mon) begin
      chk("mon_a_valid", 64'(ia.valid_out), 64'(m[0][0].v));
      if (m[0][0].v) begin
        chk("mon_a_imm", 64'(ia.immed_ext), {32'b0, m[0][0].d[31:0]});
        chk("mon_a_err", 64'(ia.imm_err), 64'(m[0][0].e));
      end
      chk("mon_b_valid", 64'(ib.valid_out), 64'(m[1][2].v));
      if (m[1][2].v) begin
        chk("mon_b_imm", ib.immed_ext, m[1][2].d);
        chk("mon_b_err", 64'(ib.imm_err), 64'(m[1][2].e));
      end
`ifdef IMM_ERR_CNT_EN
      chk("mon_a_cnt", 64'(ia.err_count), 64'(cnt[0]));
      chk("mon_b_cnt", 64'(ib.err_count), 64'(cnt[1]));
`endif
    end
  end

  typedef struct {logic [31:0] ir; logic [2:0] sel; logic [31:0] e32; logic [63:0] e64; logic err;} vec_t;
  vec_t tv [9];

  initial begin
    tv[0] = '{32'hFFF00093, 3'd0, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 1'b0};
    tv[1] = '{32'hFE112E23, 3'd1, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 1'b0};
    tv[2] = '{32'hFE000EE3, 3'd2, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 1'b0};
    tv[3] = '{32'h12345037, 3'd3, 32'h12345000, 64'h00000000_12345000, 1'b0};
    tv[4] = '{32'h80000037, 3'd3, 32'h80000000, 64'hFFFFFFFF_80000000, 1'b0};
    tv[5] = '{32'h0080006F, 3'd4, 32'h00000008, 64'h00000000_00000008, 1'b0};
    tv[6] = '{32'h800A8073, 3'd5, 32'h00000015, 64'h00000000_00000015, 1'b0};
    tv[7] = '{32'hFFFFFFFF, 3'd6, 32'h00000000, 64'h00000000_00000000, 1'b1};
    tv[8] = '{32'h12345678, 3'd7, 32'h00000000, 64'h00000000_00000000, 1'b1};

    mon = 1'b0;
    drive(32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_a_imm", 64'(ia.immed_ext), 64'd0);
    chk("rst_a_valid", 64'(ia.valid_out), 64'd0);
    chk("rst_a_err", 64'(ia.imm_err), 64'd0);
    chk("rst_b_imm", ib.immed_ext, 64'd0);
    chk("rst_b_valid", 64'(ib.valid_out), 64'd0);
    chk("rst_b_err", 64'(ib.imm_err), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 9; t++) begin
      @(negedge clk);
      drive(tv[t].ir, tv[t].sel, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      drive(32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("vec%0d_a_valid", t), 64'(ia.valid_out), 64'd1);
      chk($sformatf("vec%0d_a_imm", t), 64'(ia.immed_ext), 64'(tv[t].e32));
      chk($sformatf("vec%0d_a_err", t), 64'(ia.imm_err), 64'(tv[t].err));
      repeat (2) @(negedge clk);
      chk($sformatf("vec%0d_b_valid", t), 64'(ib.valid_out), 64'd1);
      chk($sformatf("vec%0d_b_imm", t), ib.immed_ext, tv[t].e64);
      chk($sformatf("vec%0d_b_err", t), 64'(ib.imm_err), 64'(tv[t].err));
    end

    // four entries with a two-cycle stall between the second and third; stalled inputs are dropped
    repeat (4) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k >= 1) begin
        chk($sformatf("stall_b_valid%0d", k), 64'(ib.valid_out), (k >= 5 && k <= 8) ? 64'd1 : 64'd0);
        if (k >= 5 && k <= 8) chk($sformatf("stall_b_imm%0d", k), ib.immed_ext, 64'(k - 4));
      end
      if (k >= 2 && k <= 4) begin
        chk($sformatf("stall_a_hold%0d", k), 64'(ia.immed_ext), 64'd2);
        chk($sformatf("stall_a_valid%0d", k), 64'(ia.valid_out), 64'd1);
      end
      if (k == 5) chk("stall_a_next", 64'(ia.immed_ext), 64'd3);
      case (k)
        0: drive(32'h00100093, 3'd0, 1'b1, 1'b0, 1'b0);
        1: drive(32'h00200093, 3'd0, 1'b1, 1'b0, 1'b0);
        2, 3: drive(32'h7FF00093, 3'd0, 1'b1, 1'b1, 1'b0);
        4: drive(32'h00300093, 3'd0, 1'b1, 1'b0, 1'b0);
        5: drive(32'h00400093, 3'd0, 1'b1, 1'b0, 1'b0);
        default: drive(32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
      endcase
    end

    // fill, then flush together with stall and a new entry: nothing may survive
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(32'hFFF00093, 3'd6, 1'b1, 1'b0, 1'b0);
    end
    @(negedge clk);
    drive(32'hFFF00093, 3'd0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("flush_a_valid%0d", k), 64'(ia.valid_out), 64'd0);
      chk($sformatf("flush_b_valid%0d", k), 64'(ib.valid_out), 64'd0);
      chk($sformatf("flush_b_err%0d", k), 64'(ib.imm_err), 64'd0);
    end

    // an illegal selector without valid_in must not raise imm_err
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(32'hFFFFFFFF, 3'd6, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    chk("inv_a_err", 64'(ia.imm_err), 64'd0);
    chk("inv_b_err", 64'(ib.imm_err), 64'd0);
    chk("inv_b_valid", 64'(ib.valid_out), 64'd0);

    // asynchronous reset between edges with entries in flight
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(32'hFFF00093, 3'd0, 1'b1, 1'b0, 1'b0);
    end
    @(posedge clk);
    #2;
    chk("arst_pre_b_valid", 64'(ib.valid_out), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_a_imm", 64'(ia.immed_ext), 64'd0);
    chk("arst_a_valid", 64'(ia.valid_out), 64'd0);
    chk("arst_b_imm", ib.immed_ext, 64'd0);
    chk("arst_b_valid", 64'(ib.valid_out), 64'd0);
    chk("arst_b_err", 64'(ib.imm_err), 64'd0);
    @(negedge clk);
    drive(32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    mon = 1'b1;
    repeat (400) begin
      @(negedge clk);
      drive($urandom, 3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0);
    end
    @(negedge clk);
    drive(32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    mon = 1'b0;

`ifdef IMM_ERR_CNT_EN
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("cnt_rst_a", 64'(ia.err_count), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive($urandom, 3'd7, 1'b1, 1'b0, 1'b0);
    end
    @(negedge clk);
    drive(32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("cnt3_a", 64'(ia.err_count), 64'd3);
    chk("cnt3_b", 64'(ib.err_count), 64'd3);
    repeat (300) begin
      @(negedge clk);
      drive($urandom, 3'd6, 1'b1, 1'b0, 1'b0);
    end
    @(negedge clk);
    drive(32'h0, 3'd0, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    chk("cnt_sat_a", 64'(ia.err_count), 64'd255);
    chk("cnt_sat_b", 64'(ib.err_count), 64'd255);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/immed_gen_pipe.md
Name: immed_gen_pipe

Overview:
Parametrised, pipelined successor to the decode-stage immediate generator for the OTTER pipeline.
- Extracts the I/S/B/U/J immediates and the new Z-type immediate (CSR zimm) from an instruction word.
- Sign-extends the result to XLEN.
- Delivers the result through STAGES register stages, with valid tracking, hazard-unit stall/flush and an illegal-selector flag.
- Sits between the IF/ID pipeline register and the ID/EX operand muxes.

Parameters:
XLEN, 32, output datapath width; legal values 32 or 64.
STAGES, 1, number of register stages (1..3); sets the latency.

Ports:
clk  input  1  pipeline clock
rst_n  input  1  asynchronous active-low reset
ir  input  32  instruction word
immed_sel  input  3  format select: 000 I, 001 S, 010 B, 011 U, 100 J, 101 Z
valid_in  input  1  ir/immed_sel qualify this cycle
stall  input  1  hold all stages (hazard unit)
flush  input  1  kill all in-flight entries (branch/jump)
immed_ext  output  XLEN  registered immediate
valid_out  output  1  immed_ext qualifies
imm_err  output  1  registered; the delivered entry had an illegal immed_sel

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n). While rst_n=0, every stage is cleared immediately: valid=0, data=0, err=0. Outputs therefore read immed_ext=0, valid_out=0, imm_err=0. Reset mid-stream discards all entries.
- Formats (bit 31 is the sign, replicated up to XLEN):
  - I = sext(ir[31:20])
  - S = sext({ir[31:25], ir[11:7]})
  - B = sext({ir[31], ir[7], ir[30:25], ir[11:8], 0})
  - U = sext({ir[31:12], 12'b0}) (RV64 semantics when XLEN=64)
  - J = sext({ir[31], ir[19:12], ir[20], ir[30:21], 0})
  - Z = zero-extend(ir[19:15])
- Illegal immed_sel (110, 111) with valid_in=1: the entry carries data=0 and err=1. err never sets for invalid entries.
- Stage 0 capture, on each clk edge with stall=0 and flush=0:
  - valid <= valid_in.
  - data/err load only when valid_in=1; otherwise they hold their previous value to limit toggling.
- Stage k>0 captures stage k-1 in the same way. Latency is exactly STAGES cycles when there is no stall.
- stall=1: every stage holds valid, data and err. Inputs presented during a stall are dropped; the upstream stage is stalled by the same signal.
- flush=1: all stage valid and err bits clear on the next edge; data is retained. flush has priority over stall.
- flush together with valid_in: the incoming entry is also killed.
- valid_out/imm_err/immed_ext come from the last stage. imm_err is only meaningful when valid_out=1.
- XLEN values outside {32, 64} or STAGES outside 1..3 cause an elaboration-time fatal error.

Optional Feature:
- Macro: IMM_ERR_CNT_EN.
- Defined: adds output err_count[7:0].
  - Saturating count of illegal-selector entries reaching valid_out.
  - Increments once per delivered entry with imm_err=1; held during stall; saturates at 255.
  - Cleared only by rst_n.
- Undefined: the port and counter do not exist; the rest of the behaviour is identical.

Decomposition:
- Shared package otter_imm_pkg holds:
  - typedef enum logic [2:0] imm_sel_t (IMM_I=000, IMM_S, IMM_B, IMM_U, IMM_J, IMM_Z=101)
  - localparams for the legal XLEN values and the maximum STAGES
- One natural sub-module: imm_extract, a combinational format decode plus sign extension, parametrised by XLEN, returning {err, data}.
- The top level instantiates imm_extract followed by a generate loop of STAGES stage registers.

Test Plan:
- XLEN=32, STAGES=1, ir=0xFFF00093 (addi x1,x0,-1), sel=000, valid_in=1 -> next cycle immed_ext=0xFFFFFFFF, valid_out=1, imm_err=0.
- ir=0xFE000EE3 (beq x0,x0,-4), sel=010 -> immed_ext=0xFFFFFFFC. ir=0x12345037, sel=011 -> 0x12345000. Sel=101 with ir[19:15]=10101 -> 0x00000015.
- XLEN=64, ir=0x80000037, sel=011 -> immed_ext=0xFFFFFFFF80000000. Sel=101 with ir[31]=1 -> upper bits 0.
- STAGES=3, a back-to-back stream of 4 entries:
  - stall for 2 cycles mid-stream -> outputs hold, order is preserved, total latency is 3+2 cycles.
  - flush asserted together with stall -> valid_out=0 on the next cycle and no entry survives.
- sel=110, valid_in=1 -> immed_ext=0, imm_err=1, valid_out=1 after the latency. The same sel with valid_in=0 -> imm_err stays 0.
- rst_n asserted asynchronously between clk edges while entries are in flight -> outputs zero immediately. With IMM_ERR_CNT_EN, 300 illegal entries -> err_count=255.
